// File: rtl/control_if.sv
// Datapath control interface: opcode/run-enable into the controller, control strobes,
// mux selects and status back out to the datapath.
interface control_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 16
);
  logic                    c_i_ce;
  logic [OPCODE_WIDTH-1:0] c_i_opcode;
  logic                    c_o_ce;
  logic                    c_o_IRWrite;
  logic                    c_o_PCWrite;
  logic                    c_o_RegDst;
  logic                    c_o_RegWrite;
  logic                    c_o_Branch;
  logic                    c_o_ALUSrc;
  logic [1:0]              c_o_ALUOp;
  logic                    c_o_MemRead;
  logic                    c_o_MemWrite;
  logic                    c_o_MemtoReg;
  logic                    c_o_illegal;
  logic [CNT_WIDTH-1:0]    c_o_retired;

  // The controller is the driving end of the control signals.
  modport master (
    input  c_i_ce, c_i_opcode,
    output c_o_ce, c_o_IRWrite, c_o_PCWrite, c_o_RegDst, c_o_RegWrite, c_o_Branch,
           c_o_ALUSrc, c_o_ALUOp, c_o_MemRead, c_o_MemWrite, c_o_MemtoReg,
           c_o_illegal, c_o_retired
  );

  modport slave (
    output c_i_ce, c_i_opcode,
    input  c_o_ce, c_o_IRWrite, c_o_PCWrite, c_o_RegDst, c_o_RegWrite, c_o_Branch,
           c_o_ALUSrc, c_o_ALUOp, c_o_MemRead, c_o_MemWrite, c_o_MemtoReg,
           c_o_illegal, c_o_retired
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB per opcode,
// drives datapath control and counts retired instructions.
module control_fsm #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 16
) (
  input  logic      c_clk,
  input  logic      c_rst,
  control_if.master bus
);

  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_MEM_ADDR, S_MEM_RD, S_WB_MEM,
    S_MEM_WR, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP
  } state_t;

  typedef struct packed {
    logic       ce;
    logic       ir_write;
    logic       pc_write;
    logic       reg_dst;
    logic       reg_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  state_t               state;
  state_t               next_state;
  ctrl_t                ctrl_q;
  logic [CNT_WIDTH-1:0] retired;
  logic                 illegal_op;
  logic                 retire;
  logic                 run;

  // Moore output table; registered so outputs of a state appear the cycle it is held.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c    = '0;
    c.ce = (s != S_IDLE);
    case (s)
      S_FETCH:    begin c.ir_write  = 1'b1; c.pc_write   = 1'b1; end
      S_EXEC_R:   c.alu_op = 2'b10;
      S_WB_R:     begin c.reg_dst   = 1'b1; c.reg_write  = 1'b1; end
      S_MEM_ADDR: c.alu_src = 1'b1;
      S_MEM_RD:   c.mem_read = 1'b1;
      S_WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.alu_src   = 1'b1; c.mem_write  = 1'b1; end
      S_EXEC_I:   c.alu_src = 1'b1;
      S_WB_I:     c.reg_write = 1'b1;
      S_BRANCH:   begin c.branch    = 1'b1; c.alu_op     = 2'b01; end
      S_JUMP:     c.pc_write = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    next_state = S_DECODE;
      S_DECODE: begin
        case (bus.c_i_opcode)
          OP_R:         next_state = S_EXEC_R;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_ADDI:      next_state = S_EXEC_I;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: next_state = (bus.c_i_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_EXEC_R:   next_state = S_WB_R;
      S_MEM_RD:   next_state = S_WB_MEM;
      S_EXEC_I:   next_state = S_WB_I;
      default: begin
        // WB_R, WB_MEM, MEM_WR, WB_I, BRANCH and JUMP close an instruction.
        next_state = S_FETCH;
        retire     = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous to c_clk.
  always_ff @(posedge c_clk) begin
    if (c_rst) begin
      state   <= S_IDLE;
      ctrl_q  <= '0;
      retired <= '0;
    end else if (bus.c_i_ce) begin
      state  <= next_state;
      ctrl_q <= decode(next_state);
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Stall or reset kills the strobes; mux selects keep the frozen state's values.
  assign run = bus.c_i_ce & ~c_rst;

  assign bus.c_o_ce       = ctrl_q.ce        & run;
  assign bus.c_o_IRWrite  = ctrl_q.ir_write  & run;
  assign bus.c_o_PCWrite  = ctrl_q.pc_write  & run;
  assign bus.c_o_RegWrite = ctrl_q.reg_write & run;
  assign bus.c_o_Branch   = ctrl_q.branch    & run;
  assign bus.c_o_MemRead  = ctrl_q.mem_read  & run;
  assign bus.c_o_MemWrite = ctrl_q.mem_write & run;
  assign bus.c_o_RegDst   = ctrl_q.reg_dst;
  assign bus.c_o_ALUSrc   = ctrl_q.alu_src;
  assign bus.c_o_ALUOp    = ctrl_q.alu_op;
  assign bus.c_o_MemtoReg = ctrl_q.mem_to_reg;
  assign bus.c_o_illegal  = illegal_op & run;
  assign bus.c_o_retired  = retired;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: table of per-cycle vectors plus hand-written
// stall, wrap and mid-instruction reset sequences.
module tb_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Bit order: ce irw pcw regdst regwr branch alusrc aluop[1:0] memrd memwr memtoreg illegal
  localparam logic [12:0] E_ZERO   = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_IDLE   = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_FETCH  = 13'b1_1_1_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_DECODE = 13'b1_0_0_0_0_0_0_00_0_0_0_0;
  localparam logic [12:0] E_ILL    = 13'b1_0_0_0_0_0_0_00_0_0_0_1;
  localparam logic [12:0] E_EXEC_R = 13'b1_0_0_0_0_0_0_10_0_0_0_0;
  localparam logic [12:0] E_WB_R   = 13'b1_0_0_1_1_0_0_00_0_0_0_0;
  localparam logic [12:0] E_MADDR  = 13'b1_0_0_0_0_0_1_00_0_0_0_0;
  localparam logic [12:0] E_MRD    = 13'b1_0_0_0_0_0_0_00_1_0_0_0;
  localparam logic [12:0] E_WBMEM  = 13'b1_0_0_0_1_0_0_00_0_0_1_0;
  localparam logic [12:0] E_MWR    = 13'b1_0_0_0_0_0_1_00_0_1_0_0;
  localparam logic [12:0] E_EXEC_I = 13'b1_0_0_0_0_0_1_00_0_0_0_0;
  localparam logic [12:0] E_WB_I   = 13'b1_0_0_0_1_0_0_00_0_0_0_0;
  localparam logic [12:0] E_BR     = 13'b1_0_0_0_0_1_0_01_0_0_0_0;
  localparam logic [12:0] E_BR_HLD = 13'b0_0_0_0_0_0_0_01_0_0_0_0;
  localparam logic [12:0] E_JMP    = 13'b1_0_1_0_0_0_0_00_0_0_0_0;

  typedef struct {
    logic        ce;
    logic [5:0]  op;
    logic [12:0] exp;
    logic [15:0] ret;
    string       name;
  } vec_t;

  logic c_clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  always #5 c_clk = ~c_clk;

  control_if                 bus_a ();
  control_if #(.CNT_WIDTH(2)) bus_b ();

  control_fsm dut_a (.c_clk(c_clk), .c_rst(rst_a), .bus(bus_a));
  control_fsm #(.CNT_WIDTH(2)) dut_b (.c_clk(c_clk), .c_rst(rst_b), .bus(bus_b));

  function automatic logic [12:0] pack_a();
    return {bus_a.c_o_ce, bus_a.c_o_IRWrite, bus_a.c_o_PCWrite, bus_a.c_o_RegDst,
            bus_a.c_o_RegWrite, bus_a.c_o_Branch, bus_a.c_o_ALUSrc, bus_a.c_o_ALUOp,
            bus_a.c_o_MemRead, bus_a.c_o_MemWrite, bus_a.c_o_MemtoReg, bus_a.c_o_illegal};
  endfunction

  function automatic logic [12:0] pack_b();
    return {bus_b.c_o_ce, bus_b.c_o_IRWrite, bus_b.c_o_PCWrite, bus_b.c_o_RegDst,
            bus_b.c_o_RegWrite, bus_b.c_o_Branch, bus_b.c_o_ALUSrc, bus_b.c_o_ALUOp,
            bus_b.c_o_MemRead, bus_b.c_o_MemWrite, bus_b.c_o_MemtoReg, bus_b.c_o_illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ce, input logic [5:0] op, input logic [12:0] exp,
                     input logic [15:0] ret, input string name);
    vec_t v;
    v.ce = ce; v.op = op; v.exp = exp; v.ret = ret; v.name = name;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs, check the current state's outputs, advance one clock.
  task automatic step_a(input logic ce, input logic [5:0] op, input logic [12:0] exp,
                        input logic [15:0] ret, input string name);
    bus_a.c_i_ce     = ce;
    bus_a.c_i_opcode = op;
    #1;
    check({name, ".ctrl"}, 32'(pack_a()), 32'(exp));
    check({name, ".retired"}, 32'(bus_a.c_o_retired), 32'(ret));
    @(posedge c_clk);
    #1;
  endtask

  task automatic step_b(input logic ce, input logic [5:0] op, input logic [12:0] exp,
                        input logic [1:0] ret, input string name);
    bus_b.c_i_ce     = ce;
    bus_b.c_i_opcode = op;
    #1;
    check({name, ".ctrl"}, 32'(pack_b()), 32'(exp));
    check({name, ".retired"}, 32'(bus_b.c_o_retired), 32'(ret));
    @(posedge c_clk);
    #1;
  endtask

  initial begin
    // Main table: lw, sw, R, addi, beq, j, illegal back to back.
    add(1, OP_LW,   E_IDLE,   0, "idle");
    add(1, OP_LW,   E_FETCH,  0, "lw.fetch");
    add(1, OP_LW,   E_DECODE, 0, "lw.decode");
    add(1, OP_LW,   E_MADDR,  0, "lw.mem_addr");
    add(1, OP_LW,   E_MRD,    0, "lw.mem_rd");
    add(1, OP_LW,   E_WBMEM,  0, "lw.wb_mem");
    add(1, OP_SW,   E_FETCH,  1, "sw.fetch");
    add(1, OP_SW,   E_DECODE, 1, "sw.decode");
    add(1, OP_SW,   E_MADDR,  1, "sw.mem_addr");
    add(1, OP_SW,   E_MWR,    1, "sw.mem_wr");
    add(1, OP_R,    E_FETCH,  2, "r.fetch");
    add(1, OP_R,    E_DECODE, 2, "r.decode");
    add(1, OP_R,    E_EXEC_R, 2, "r.exec");
    add(1, OP_R,    E_WB_R,   2, "r.wb");
    add(1, OP_ADDI, E_FETCH,  3, "addi.fetch");
    add(1, OP_ADDI, E_DECODE, 3, "addi.decode");
    add(1, OP_ADDI, E_EXEC_I, 3, "addi.exec");
    add(1, OP_ADDI, E_WB_I,   3, "addi.wb");
    add(1, OP_BEQ,  E_FETCH,  4, "beq.fetch");
    add(1, OP_BEQ,  E_DECODE, 4, "beq.decode");
    add(1, OP_BEQ,  E_BR,     4, "beq.branch");
    add(1, OP_J,    E_FETCH,  5, "j.fetch");
    add(1, OP_J,    E_DECODE, 5, "j.decode");
    add(1, OP_J,    E_JMP,    5, "j.jump");
    add(1, OP_BAD,  E_FETCH,  6, "bad.fetch");
    add(1, OP_BAD,  E_ILL,    6, "bad.decode");
    add(1, OP_LW,   E_FETCH,  6, "bad.refetch");

    bus_a.c_i_ce = 1'b1; bus_a.c_i_opcode = OP_LW;
    bus_b.c_i_ce = 1'b1; bus_b.c_i_opcode = OP_J;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset held two cycles with ce high: reset must win.
    repeat (2) @(posedge c_clk);
    #1;
    check("reset.ctrl", 32'(pack_a()), 32'(E_ZERO));
    check("reset.retired", 32'(bus_a.c_o_retired), 32'd0);
    rst_a = 1'b0;

    foreach (tbl[i]) step_a(tbl[i].ce, tbl[i].op, tbl[i].exp, tbl[i].ret, tbl[i].name);

    // lw stalled three cycles in MEM_RD; MemRead re-issued once on resume (8 cycles total).
    step_a(1, OP_LW, E_DECODE, 6, "stall.decode");
    step_a(1, OP_LW, E_MADDR,  6, "stall.mem_addr");
    for (int k = 0; k < 3; k++) step_a(0, OP_LW, E_ZERO, 6, "stall.frozen");
    step_a(1, OP_LW, E_MRD,    6, "stall.resume");
    step_a(1, OP_LW, E_WBMEM,  6, "stall.wb_mem");

    // beq stalled in BRANCH: Branch drops, ALUOp select holds 01.
    step_a(1, OP_BEQ, E_FETCH,  7, "bstall.fetch");
    step_a(1, OP_BEQ, E_DECODE, 7, "bstall.decode");
    step_a(0, OP_BEQ, E_BR_HLD, 7, "bstall.frozen");
    step_a(1, OP_BEQ, E_BR,     7, "bstall.resume");

    // Illegal opcode while stalled in DECODE: no pulse until ce returns.
    step_a(1, OP_BAD, E_FETCH,  8, "istall.fetch");
    step_a(0, OP_BAD, E_ZERO,   8, "istall.frozen");
    step_a(1, OP_BAD, E_ILL,    8, "istall.resume");
    step_a(1, OP_BAD, E_FETCH,  8, "istall.refetch");

    // Narrow counter: five jumps count 1,2,3,0,1; then reset aborts a lw in MEM_ADDR.
    rst_b = 1'b0;
    step_b(1, OP_J, E_IDLE, 0, "wrap.idle");
    for (int k = 0; k < 5; k++) begin
      step_b(1, OP_J, E_FETCH,  2'(k), "wrap.fetch");
      step_b(1, OP_J, E_DECODE, 2'(k), "wrap.decode");
      step_b(1, OP_J, E_JMP,    2'(k), "wrap.jump");
    end
    step_b(1, OP_LW, E_FETCH,  2'd1, "abort.fetch");
    step_b(1, OP_LW, E_DECODE, 2'd1, "abort.decode");
    bus_b.c_i_ce = 1'b1;
    #1;
    check("abort.mem_addr.ctrl", 32'(pack_b()), 32'(E_MADDR));
    rst_b = 1'b1;
    @(posedge c_clk);
    #1;
    check("abort.reset.ctrl", 32'(pack_b()), 32'(E_ZERO));
    check("abort.reset.retired", 32'(bus_b.c_o_retired), 32'd0);
    rst_b = 1'b0;
    step_b(1, OP_LW, E_IDLE,  2'd0, "abort.idle");
    step_b(1, OP_LW, E_FETCH, 2'd0, "abort.refetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
